uart_status_tx: RTL and testbench

//   Transmit-side UART telemetry framer: snapshots the 32-bit game status word
//   (header, monster HP, player HP, spare byte) on request and serialises it on

---
 rtl/uart_status_tx.sv | 132 +++++++++++++
 tb/tb_uart_status_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_status_tx.sv
// rtl/uart_status_tx.sv - 8N1 UART framer that snapshots a 32-bit status word and sends it as a 6-byte frame
module uart_status_tx #(
  parameter int          CLKS_PER_BIT = 10416,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        send,
  input  logic [31:0] state,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]   bit_idx_q, bit_idx_d;
  logic [2:0]   byte_idx_q, byte_idx_d;
  logic [31:0]  snap_q, snap_d;
  logic         tx_q, tx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         baud_last;
  logic [7:0]   next_byte;

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    fsm_d      = fsm_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    snap_d     = snap_q;
    done_d     = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (send && !busy_q) begin
          snap_d     = state;
          byte_idx_d = 3'd0;
          bit_idx_d  = 3'd0;
          baud_d     = '0;
          fsm_d      = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          fsm_d     = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) fsm_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (byte_idx_q == 3'd5) begin
            byte_idx_d = 3'd0;
            fsm_d      = S_IDLE;
            done_d     = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            fsm_d      = S_START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so tx/busy change on the same edge as the FSM.
  always_comb begin
    case (byte_idx_d)
      3'd0:    next_byte = HEADER;
      3'd1:    next_byte = snap_d[31:24];
      3'd2:    next_byte = snap_d[23:16];
      3'd3:    next_byte = snap_d[15:8];
      3'd4:    next_byte = snap_d[7:0];
      3'd5:    next_byte = snap_d[31:24] ^ snap_d[23:16] ^ snap_d[15:8] ^ snap_d[7:0];
      default: next_byte = HEADER;
    endcase
    case (fsm_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = next_byte[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (fsm_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q      <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      snap_q     <= 32'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      snap_q     <= snap_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_status_tx.sv
// tb/tb_uart_status_tx.sv - scoreboard bench: UART decoder and busy/done monitors check queued frames
module tb_uart_status_tx;

  localparam int C     = 4;
  localparam int FRAME = 60 * C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        send;
  logic [31:0] state;
  logic        tx, busy, done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         done_q[$];
  int         done_cnt = 0;
  int         cyc = 0;

  uart_status_tx #(.CLKS_PER_BIT(C), .HEADER(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .send(send), .state(state),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] s);
    exp_q.push_back(8'hA5);
    exp_q.push_back(s[31:24]);
    exp_q.push_back(s[23:16]);
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
    exp_q.push_back(s[31:24] ^ s[23:16] ^ s[15:8] ^ s[7:0]);
  endtask

  // Leaves the bench 2 time units after the accepting edge.
  task automatic send_pulse(input logic [31:0] s);
    @(posedge clk); #2;
    send  = 1'b1;
    state = s;
    @(posedge clk); #2;
    send  = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  // UART decoder: samples mid-bit on the falling edge, pops and compares each byte.
  initial begin
    logic       active;
    int         cnt;
    logic [7:0] sh;
    active = 1'b0;
    cnt    = 0;
    sh     = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active = 1'b0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
        end
      end else begin
        cnt++;
        if (cnt == C / 2) chk("start_bit", {31'd0, tx}, 32'd0);
        for (int k = 0; k < 8; k++)
          if (cnt == C / 2 + C * (k + 1)) sh[k] = tx;
        if (cnt == C / 2 + 9 * C) begin
          chk("stop_bit", {31'd0, tx}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL byte_unexpected actual=%0h expected=none", sh);
          end else begin
            chk("byte", {24'd0, sh}, {24'd0, exp_q.pop_front()});
          end
          active = 1'b0;
        end
      end
    end
  end

  // busy/done monitor: frame length, busy duration, done timing.
  initial begin
    logic prev_busy;
    int   busy_run;
    int   start_cyc;
    prev_busy = 1'b0;
    busy_run  = 0;
    start_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        prev_busy = 1'b0;
        busy_run  = 0;
      end else begin
        if (busy && !prev_busy) begin
          start_cyc = cyc;
          start_q.push_back(cyc);
          chk("tx_low_at_start", {31'd0, tx}, 32'd0);
        end
        if (busy) begin
          busy_run++;
        end else if (prev_busy) begin
          chk("busy_len", busy_run, FRAME);
          busy_run = 0;
        end
        if (done) begin
          done_cnt++;
          done_q.push_back(cyc);
          chk("frame_len", cyc - start_cyc, FRAME);
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    int base;
    reset_n = 1'b0;
    send    = 1'b0;
    state   = 32'd0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // 1: idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
    end

    // 2: single frame
    base = done_cnt;
    push_frame(32'h90326400);
    send_pulse(32'h90326400);
    wait_done(base + 1, FRAME + 20);
    repeat (20) @(posedge clk);
    chk("s2_done_count", done_cnt, base + 1);

    // 3: send mid-frame ignored
    base = done_cnt;
    push_frame(32'h90326400);
    send_pulse(32'h90326400);
    repeat (50) @(posedge clk);
    send_pulse(32'hFFFFFFFF);
    wait_done(base + 1, FRAME + 20);
    repeat (20) @(posedge clk);
    chk("s3_done_count", done_cnt, base + 1);
    chk("s3_idle_busy", {31'd0, busy}, 32'd0);

    // 4: send held high, back-to-back frames
    base = done_cnt;
    start_q.delete();
    done_q.delete();
    push_frame(32'h01020304);
    push_frame(32'h01020304);
    @(posedge clk); #2;
    send  = 1'b1;
    state = 32'h01020304;
    wait_done(base + 1, FRAME + 20);
    repeat (3) @(posedge clk);
    #2 send = 1'b0;
    wait_done(base + 2, FRAME + 20);
    repeat (20) @(posedge clk);
    chk("s4_done_count", done_cnt, base + 2);
    chk("s4_frames", start_q.size(), 2);
    if (start_q.size() == 2 && done_q.size() == 2) begin
      chk("s4_restart", start_q[1] - done_q[0], 1);
      chk("s4_done_gap", done_q[1] - done_q[0], FRAME + 1);
    end

    // 5: reset during byte 2, bit 3
    base = done_cnt;
    push_frame(32'h11325588);
    send_pulse(32'h11325588);
    repeat (97) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("s5_async_tx", {31'd0, tx}, 32'd1);
    chk("s5_async_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("s5_no_done", done_cnt, base);
    push_frame(32'hDEADBEEF);
    send_pulse(32'hDEADBEEF);
    wait_done(base + 1, FRAME + 20);
    repeat (20) @(posedge clk);

    // 6: state scrambled after accept
    base = done_cnt;
    push_frame(32'h12345678);
    send_pulse(32'h12345678);
    for (int i = 0; i < FRAME + 10; i++) begin
      @(posedge clk); #2;
      state = $urandom;
    end
    wait_done(base + 1, 40);
    repeat (20) @(posedge clk);
    chk("s6_done_count", done_cnt, base + 1);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
